burst_word_packer: RTL and testbench
====================================

// Module: burst_word_packer
// PURPOSE
//   Downstream stage of the burst load/process FSM. Takes the byte stream that FSM
//   emits, qualified by valid/last, and packs it little-endian into 32-bit words.
//   Emits the words on a valid/ready interface towards the word-wide datapath.
//   Counts completed bursts and flags over-length bursts.
// PARAMETERS
//   BYTES_PER_WORD  4    bytes packed per output word; out_data width = 8*BYTES_PER_WORD
//   MAX_BURST       8    max bytes per burst before a forced termination
//   CNT_W           16   width of burst_count
// PORTS
//   clk          in   1       clock, all logic on rising edge
//   rst          in   1       reset, asynchronous, active-high
//   in_valid     in   1       in_data/in_last valid this cycle
//   in_data      in   8       payload byte
//   in_last      in   1       final byte of the current burst
//   in_ready     out  1       packer accepts a byte this cycle
//   out_valid    out  1       out_data/out_last valid
//   out_data     out  8*BPW   packed word, byte k at bits [8k+7:8k]
//   out_last     out  1       final word of the burst
//   out_ready    in   1       consumer accepts word this cycle
//   burst_count  out  CNT_W   bursts completed (out_last words handshaken)
//   err_len      out  1       sticky: a burst exceeded MAX_BURST bytes
// BEHAVIOUR
//   Reset: state=IDLE; out_valid=0, out_data=0, out_last=0, burst_count=0, err_len=0.
//     Accumulator, byte index and byte counter cleared. in_ready=1 after reset.
//   Handshakes: byte accepted iff in_valid&in_ready; word accepted iff out_valid&out_ready.
//     out_data/out_last hold stable while out_valid&!out_ready.
//   in_ready = (state==IDLE||state==FILL) && !(out_valid && !out_ready).
//   FSM states: IDLE, FILL, HOLD, CKSUM.
//     IDLE -> FILL on the first accepted byte.
//     FILL: byte goes into lane idx; idx++.
//     Word complete when idx reaches BPW-1, or in_last, or byte count hits MAX_BURST.
//       On completion the word moves to the output register on the same edge;
//       out_valid=1 the next cycle (1-cycle latency from the completing byte).
//     Unfilled lanes of a partial word are zero.
//     out_last=1 on the final word of the burst (non-checksum mode).
//     After the final word -> HOLD. HOLD -> IDLE when that word handshakes.
//   Forced termination: the MAX_BURST-th byte arrives without in_last.
//     Treated as last: out_last=1, err_len set (sticky until rst).
//     Following bytes start a new burst.
//   Simultaneous: output drain and a completing byte in the same cycle are both
//     accepted; the new word replaces the old one with no bubble.
//   burst_count++ on each handshaken out_last word; wraps 2^CNT_W-1 -> 0.
//   in_last on the first byte -> single word, lane 0 only.
//   rst mid-burst discards the partial word and any pending output immediately.
// CONFIGURATION
//   BURST_CHECKSUM_EN defined:
//     After the final data word, state CKSUM emits one extra word {zeros, sum8}.
//     sum8 = mod-256 sum of all bytes of the burst.
//     out_last moves to the checksum word; the final data word has out_last=0.
//     in_ready=0 in CKSUM.
//   Undefined: no CKSUM state, no checksum word; out_last is on the final data word.
// TESTING
//   1. Bytes 01..08, last on 08, out_ready=1
//      -> words 0x04030201, 0x08070605(last); burst_count=1.
//   2. Bytes AA,BB,CC, last on CC -> one word 0x00CCBBAA, out_last=1.
//   3. out_ready=0 for 5 cycles after word 1 of test 1
//      -> out_data held; in_ready=0 while the 2nd word is pending; no data loss.
//   4. 9 bytes, no in_last -> 2nd word out_last=1, err_len=1;
//      9th byte starts a new burst.
//   5. Assert rst after 3 bytes -> no output word; all outputs at reset values next cycle.
//   6. BURST_CHECKSUM_EN, test-1 stimulus
//      -> 3rd word 0x00000024 with last; 2nd word out_last=0.

Source files
------------

// File: rtl/burst_word_packer.sv
// Packs a valid/last-qualified byte stream little-endian into BYTES_PER_WORD-byte words.
// Define BURST_CHECKSUM_EN to append a mod-256 checksum word after each burst.
module burst_word_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int MAX_BURST      = 8,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [8*BYTES_PER_WORD-1:0] out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            burst_count,
    output logic                        err_len,
    output logic [1:0]                  state_dbg
);

    localparam int W     = 8 * BYTES_PER_WORD;
    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_CKSUM = 2'd3;

    // Handshakes: a byte moves when in_valid && in_ready, a word moves when
    // out_valid && out_ready; out_data/out_last are frozen while out_valid && !out_ready.

    logic [1:0]       state;
    logic [W-1:0]     acc;
    logic [IDX_W-1:0] idx;
    logic [BC_W-1:0]  byte_cnt;
`ifdef BURST_CHECKSUM_EN
    logic [7:0]       sum;
`endif

    logic             out_stall;
    logic             in_fire;
    logic             out_fire;
    logic             hit_max;
    logic             burst_end;
    logic             word_done;
    logic [W-1:0]     word_next;

    assign state_dbg = state;
    assign out_stall = out_valid && !out_ready;
    assign in_ready  = ((state == S_IDLE) || (state == S_FILL)) && !out_stall;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign hit_max   = (byte_cnt == BC_W'(MAX_BURST - 1));
    assign burst_end = in_last || hit_max;
    assign word_done = (idx == IDX_W'(BYTES_PER_WORD - 1)) || burst_end;

    // acc only holds lanes already written this word, so unfilled lanes stay zero.
    always_comb begin
        word_next = acc;
        word_next[{idx, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            acc         <= '0;
            idx         <= '0;
            byte_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            burst_count <= '0;
            err_len     <= 1'b0;
`ifdef BURST_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
                if (out_last) begin
                    burst_count <= burst_count + 1'b1;
                end
            end

            case (state)
                S_IDLE, S_FILL: begin
                    if (in_fire) begin
                        if (word_done) begin
                            // Loading here overrides the drain above: no bubble.
                            out_data  <= word_next;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            idx       <= '0;
                            if (burst_end) begin
                                byte_cnt <= '0;
                                if (hit_max && !in_last) begin
                                    err_len <= 1'b1;
                                end
`ifdef BURST_CHECKSUM_EN
                                out_last <= 1'b0;
                                sum      <= sum + in_data;
                                state    <= S_CKSUM;
`else
                                out_last <= 1'b1;
                                state    <= S_HOLD;
`endif
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                                out_last <= 1'b0;
                                state    <= S_FILL;
`ifdef BURST_CHECKSUM_EN
                                sum      <= sum + in_data;
`endif
                            end
                        end else begin
                            acc      <= word_next;
                            idx      <= idx + 1'b1;
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= S_FILL;
`ifdef BURST_CHECKSUM_EN
                            sum      <= sum + in_data;
`endif
                        end
                    end
                end
                S_HOLD: begin
                    if (out_fire) begin
                        state <= S_IDLE;
                    end
                end
                S_CKSUM: begin
`ifdef BURST_CHECKSUM_EN
                    if (!out_valid || out_ready) begin
                        out_data  <= W'(sum);
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                        sum       <= '0;
                        state     <= S_HOLD;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_word_packer.sv
// Bench for burst_word_packer: directed vector table, hand-written corner sequences,
// and random byte streams checked against a burst-level reference model.
module tb_burst_word_packer;

    localparam int BPW = 4;
    localparam int MAXB = 8;
    localparam int CW = 16;
`ifdef BURST_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic [CW-1:0] burst_count;
    logic          err_len;
    logic [1:0]    state_dbg;

    burst_word_packer #(.BYTES_PER_WORD(BPW), .MAX_BURST(MAXB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .burst_count(burst_count), .err_len(err_len), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: {last, word} in expected order.
    logic [32:0]   exp_q[$];
    logic [7:0]    burst_q[$];
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_err = 1'b0;
    logic          rand_rdy = 1'b0;
    logic          last_acc = 1'b0;
    logic          prev_stall = 1'b0;
    logic [32:0]   prev_word = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: whole-burst view, words cut every BPW bytes, at last, or at MAXB.
    task automatic model_byte(input logic [7:0] d, input logic l);
        int n;
        int base;
        logic fin;
        logic [31:0] w;
        logic [7:0] s;
        burst_q.push_back(d);
        n = burst_q.size();
        fin = l || (n == MAXB);
        if (n == MAXB && !l) exp_err = 1'b1;
        if ((n % BPW) == 0 || fin) begin
            base = ((n - 1) / BPW) * BPW;
            w = '0;
            for (int k = base; k < n; k++) w = w | (32'(burst_q[k]) << (8 * (k - base)));
            exp_q.push_back({fin && !CK, w});
        end
        if (fin) begin
            if (CK) begin
                s = '0;
                foreach (burst_q[k]) s = s + burst_q[k];
                exp_q.push_back({1'b1, 24'h0, s});
            end
            burst_q.delete();
        end
    endtask

    task automatic tick();
        logic [32:0] e;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'({out_last, out_data}), 64'(prev_word));
        end
        prev_stall = out_valid && !out_ready;
        prev_word = {out_last, out_data};
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'({out_last, out_data}), 64'h1_0000_0000_0);
            end else begin
                e = exp_q.pop_front();
                chk("word", 64'({out_last, out_data}), 64'(e));
                if (e[32]) exp_cnt = exp_cnt + 1'b1;
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) model_byte(in_data, in_last);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int budget;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        budget = 0;
        last_acc = 1'b0;
        while (!last_acc && budget < 200) begin
            tick();
            budget++;
        end
        if (!last_acc) chk("accept_timeout", 64'(budget), 64'd0);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && budget < 200) begin
            tick();
            budget++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("burst_count", 64'(burst_count), 64'(exp_cnt));
        chk("err_len", 64'(err_len), 64'(exp_err));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        burst_q.delete();
        exp_cnt = '0;
        exp_err = 1'b0;
        prev_stall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_burst_count"}, 64'(burst_count), 64'd0);
        chk({tag, "_err_len"}, 64'(err_len), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ol;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
        tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
        tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
        tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
        tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
        tbl[6]  = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
        tbl[7]  = '{1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h08070605, 1'b1, 16'd0};
        tbl[9]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd1};
        tbl[10] = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd1};
        tbl[11] = '{1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00CCBBAA, 1'b1, 16'd1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 16'd2};

        do_reset();
        #1;
        chk_reset_values("reset");

`ifndef BURST_CHECKSUM_EN
        // Tests 1 and 2 as a cycle-exact vector table.
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].v;
            in_data = tbl[i].d;
            in_last = tbl[i].l;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_data", i), 64'(out_data), 64'(tbl[i].e_od));
                chk($sformatf("tbl%0d_out_last", i), 64'(out_last), 64'(tbl[i].e_ol));
            end
            chk($sformatf("tbl%0d_burst_count", i), 64'(burst_count), 64'(tbl[i].e_cnt));
            @(posedge clk);
            #1;
        end
        do_reset();
`endif

        // Test 1 / test 6 stimulus through the model.
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        drain();

        // Test 3: stall after the first word.
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h05;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_in_ready", 64'(in_ready), 64'd0);
            chk("t3_out_data", 64'({out_valid, out_data}), 64'h1_0403_0201);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) send_byte(8'(i), i == 8);
        drain();

        // Test 4: 9 bytes without last, then close the spill-over burst.
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b0);
        send_byte(8'h55, 1'b1);
        drain();
        chk("t4_err_sticky", 64'(err_len), 64'd1);

        // Test 5: reset mid-burst discards everything.
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0);
        rst = 1'b1;
        exp_q.delete();
        burst_q.delete();
        exp_cnt = '0;
        exp_err = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        chk_reset_values("t5");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        drain();

        // Random byte stream, random gaps and back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        send_byte(8'h77, 1'b1);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
